wheel_speed_calc: RTL and testbench

//  Measures wheel-sensor pulse period and converts it to speed in km/h for control (speed, speed_valid).

---
 rtl/bike_pkg.sv | 27 ++
 rtl/wheel_speed_calc_if.sv | 22 ++
 rtl/seq_divider.sv | 44 ++++
 rtl/wheel_speed_calc.sv | 114 +++++++++++
 tb/tb_wheel_speed_calc.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/bike_pkg.sv
// Shared constants, FSM encoding and helpers for the wheel speed path.
package bike_pkg;

  localparam int SPEED_WIDTH_DEF = 7;
  localparam int CLK_HZ_DEF      = 2048;
  localparam int CIRC_MM_DEF     = 2136;
  localparam int PER_WIDTH_DEF   = 16;
  localparam int TIMEOUT_DEF     = 4096;
  localparam int MIN_GAP_DEF     = 20;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } spd_state_e;

  // km/h numerator: circumference[mm] * f_clk * 3.6 / 1000, floored.
  function automatic longint calc_num(input longint circ_mm, input longint clk_hz);
    return (circ_mm * clk_hz * 36) / 10000;
  endfunction

  // Largest speed representable in a w-bit result.
  function automatic int speed_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/wheel_speed_calc_if.sv
// Sensor, control and distance-counter signals of the wheel speed block.
interface wheel_speed_calc_if #(
  parameter int SPEED_WIDTH = 7
);
  logic                   wheel_pulse;
  logic                   en_speed;
  logic                   speed_start;
  logic [SPEED_WIDTH-1:0] speed;
  logic                   speed_valid;
  logic                   busy;
  logic                   rev_pulse;

  modport master (
    output wheel_pulse, en_speed, speed_start,
    input  speed, speed_valid, busy, rev_pulse
  );

  modport slave (
    input  wheel_pulse, en_speed, speed_start,
    output speed, speed_valid, busy, rev_pulse
  );
endinterface

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, W bits.
module seq_divider #(
  parameter int W = 16
)(
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q, quo_q, dvs_q;
  logic [CW-1:0] left_q;
  logic [W:0]    rem_sh;
  logic          ge;

  assign rem_sh = {rem_q, quo_q[W-1]};
  assign ge     = (rem_sh >= {1'b0, dvs_q});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      left_q <= '0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      left_q <= CW'(W);
    end else if (left_q != '0) begin
      rem_q  <= ge ? (rem_sh[W-1:0] - dvs_q) : rem_sh[W-1:0];
      quo_q  <= {quo_q[W-2:0], ge};
      left_q <= left_q - CW'(1);
    end
  end

  // High in the cycle whose closing edge retires the last quotient bit.
  assign done     = (left_q == CW'(1));
  assign quotient = quo_q;
endmodule

// File: rtl/wheel_speed_calc.sv
// Wheel pulse period measurement and period-to-km/h conversion on request.
module wheel_speed_calc
  import bike_pkg::*;
#(
  parameter int SPEED_WIDTH = SPEED_WIDTH_DEF,
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int CIRC_MM     = CIRC_MM_DEF,
  parameter int PER_WIDTH   = PER_WIDTH_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF,
  parameter int MIN_GAP     = MIN_GAP_DEF
)(
  input logic               clock,
  input logic               reset,
  wheel_speed_calc_if.slave bus
);
  localparam longint NUM = calc_num(CIRC_MM, CLK_HZ);
  localparam int     SAT = speed_max(SPEED_WIDTH);

  logic [1:0]             sync_q;
  logic                   prev_q, rise, accept;
  logic [PER_WIDTH-1:0]   cnt_q, period_q, snap_q, quotient;
  logic                   have_edge_q, rev_q;
  spd_state_e             state_q, state_d;
  logic                   div_start, div_done;
  logic [SPEED_WIDTH-1:0] speed_q;
  logic                   valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.wheel_pulse};
      prev_q <= sync_q[1];
    end
  end

  assign rise   = sync_q[1] & ~prev_q;
  assign accept = rise & bus.en_speed & (~have_edge_q | (cnt_q >= PER_WIDTH'(MIN_GAP)));

  // An accepted edge takes priority over the timeout landing in the same cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      period_q    <= '0;
      have_edge_q <= 1'b0;
      rev_q       <= 1'b0;
    end else begin
      rev_q <= accept;
      if (accept) begin
        if (have_edge_q) period_q <= cnt_q;
        cnt_q       <= PER_WIDTH'(1);
        have_edge_q <= 1'b1;
      end else if (bus.en_speed && (cnt_q != PER_WIDTH'(TIMEOUT))) begin
        cnt_q <= cnt_q + PER_WIDTH'(1);
        if (cnt_q == PER_WIDTH'(TIMEOUT - 1)) begin
          period_q    <= '0;
          have_edge_q <= 1'b0;
        end
      end
    end
  end

  seq_divider #(.W(PER_WIDTH)) u_div (
    .clock    (clock),
    .reset    (reset),
    .start    (div_start),
    .dividend (PER_WIDTH'(NUM)),
    .divisor  (period_q),
    .quotient (quotient),
    .done     (div_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.speed_start) begin
        div_start = 1'b1;
        state_d   = ST_DIV;
      end
      ST_DIV:  if (div_done) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Divisor copy kept here so a zero period can force speed 0 at the end.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_q  <= '0;
      speed_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= (state_q == ST_DONE);
      if (div_start) snap_q <= period_q;
      if (state_q == ST_DONE) begin
        if (snap_q == '0)                       speed_q <= '0;
        else if (quotient > PER_WIDTH'(SAT))    speed_q <= SPEED_WIDTH'(SAT);
        else                                    speed_q <= quotient[SPEED_WIDTH-1:0];
      end
    end
  end

  assign bus.speed       = speed_q;
  assign bus.speed_valid = valid_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.rev_pulse   = rev_q;
endmodule

// File: tb/tb_wheel_speed_calc.sv
// Random and directed pulse trains against an event-level speed model.
module tb_wheel_speed_calc;
  localparam int TIMEOUT = 4096;
  localparam int MIN_GAP = 20;
  localparam int SMAX    = 127;
  localparam int NUM     = (2136 * 2048 * 36) / 10000;
  localparam int LAT     = 17;

  logic clock = 1'b0;
  logic reset = 1'b1;

  wheel_speed_calc_if #(.SPEED_WIDTH(7)) bus();

  wheel_speed_calc dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0, failures = 0, cyc = 0, rev_seen = 0;
  int m_have = 0, m_last = 0, m_per = 0, m_revs = 0;

  always @(negedge clock) if (bus.rev_pulse) rev_seen++;

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic model_reset();
    m_have = 0;
    m_per  = 0;
    m_last = cyc;
  endtask

  // Edge at cycle c: gap is measured between raw rise times.
  task automatic model_edge(input int c);
    int d;
    d = c - m_last;
    if (!m_have || d >= TIMEOUT) begin
      m_have = 1; m_per = 0; m_last = c; m_revs++;
    end else if (d >= MIN_GAP) begin
      m_per = d; m_last = c; m_revs++;
    end
  endtask

  task automatic pulse(input int w);
    bus.wheel_pulse = 1'b1;
    model_edge(cyc);
    idle(w);
    bus.wheel_pulse = 1'b0;
  endtask

  task automatic train(input int p, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      pulse(2);
      if (i < n - 1) begin
        if (glitch && i == 0) begin
          idle(3); pulse(1); idle(p - 6);
        end else idle(p - 2);
      end
    end
    idle(20);
  endtask

  // exp < 0 takes the model's answer; rst_at >= 0 pulses reset mid-division.
  task automatic query(input string tag, input int exp_in, input int start2_at, input int rst_at);
    int exp, first, nval;
    chk({tag, "_revs"}, rev_seen, m_revs);
    if (m_have && (cyc - m_last) >= TIMEOUT) begin m_have = 0; m_per = 0; end
    if (exp_in >= 0) exp = exp_in;
    else if (m_per == 0) exp = 0;
    else exp = (NUM / m_per > SMAX) ? SMAX : NUM / m_per;
    bus.speed_start = 1'b1;
    tick();
    bus.speed_start = 1'b0;
    first = -1;
    nval  = 0;
    for (int k = 0; k <= 40; k++) begin
      if (k == rst_at) begin
        reset = 1'b1;
        #1;
        chk({tag, "_rst_speed"}, bus.speed, 0);
        chk({tag, "_rst_busy"}, bus.busy, 0);
        chk({tag, "_rst_valid"}, bus.speed_valid, 0);
      end
      if (k == rst_at + 2) reset = 1'b0;
      if (k == 0) chk({tag, "_busy"}, bus.busy, 1);
      if (bus.speed_valid) begin
        nval++;
        if (first < 0) first = k;
      end
      if (k == start2_at) bus.speed_start = 1'b1;
      tick();
      bus.speed_start = 1'b0;
    end
    if (rst_at < 0) begin
      chk({tag, "_latency"}, first, LAT);
      chk({tag, "_nvalid"}, nval, 1);
      chk({tag, "_speed"}, bus.speed, exp);
    end else begin
      chk({tag, "_nvalid"}, nval, 0);
      chk({tag, "_speed"}, bus.speed, 0);
      model_reset();
    end
    chk({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    int p, n;
    bit g;
    bus.wheel_pulse = 1'b0;
    bus.en_speed    = 1'b1;
    bus.speed_start = 1'b0;
    reset = 1'b1;
    model_reset();
    idle(3);
    chk("rst_speed", bus.speed, 0);
    chk("rst_valid", bus.speed_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rev", bus.rev_pulse, 0);
    reset = 1'b0;
    model_reset();

    bus.en_speed = 1'b0;
    pulse(2);
    idle(10);
    m_revs = 0;
    chk("en_off_rev", rev_seen, 0);
    bus.en_speed = 1'b1;
    reset = 1'b1; idle(2); reset = 1'b0;
    model_reset();

    train(1500, 3, 1'b0); query("p1500", 10, -1, -10);
    train(238, 3, 1'b0);  query("p238", 66, -1, -10);
    train(240, 3, 1'b0);  query("p240", 65, -1, -10);
    train(100, 3, 1'b0);  query("p100", 127, -1, -10);
    idle(4200);           query("timeout", 0, -1, -10);
    pulse(2); idle(20);   query("single", 0, -1, -10);
    train(240, 2, 1'b1);  query("glitch", 65, -1, -10);
    train(19, 2, 1'b0);   query("gap19", -1, -1, -10);
    train(20, 2, 1'b0);   query("gap20", 127, -1, -10);
    train(238, 3, 1'b0);  query("start2", 66, 4, -10);
    query("mid_rst", 0, -1, 8);

    for (int i = 0; i < 8; i++) begin
      p = $urandom_range(25, 1200);
      n = $urandom_range(2, 3);
      g = 1'($urandom_range(0, 1));
      train(p, n, g);
      query($sformatf("rnd%0d", i), -1, -1, -10);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
